// File: rtl/dma_periph_flow_if.sv
// ============================================================================
// dma_periph_flow_if
//
// Peripheral-side end of the DMA flow-control interface for a byte-stream
// peripheral (UART/SPI class). It holds two byte FIFOs:
//   - TX: the DMA writes up to four byte lanes per strobe and the peripheral
//     drains one byte per handshake.
//   - RX: the peripheral pushes one byte per handshake and the DMA pops
//     either one byte or one little-endian word per read.
// It also produces the slot_av / data_av / word_av lines for one flow-mux
// input set. All flow lines come from registered counts only, so a push or
// pop shows up on them one cycle later.
//
// Optional feature (compile-time macro DMA_FLOW_RXTIMEOUT_EN):
//   When defined, data_av only reports a partial RX word (1..3 bytes) after
//   the RX FIFO has been idle for TIMEOUT cycles. When undefined, data_av is
//   simply "RX FIFO not empty" and no idle counter exists.
//
// Parameters
//   TX_DEPTH  TX FIFO depth in bytes (power of 2, >= 4)
//   RX_DEPTH  RX FIFO depth in bytes (power of 2, >= 4)
//   TIMEOUT   idle cycles before a partial RX word raises data_av
//
// Ports
//   hclk, n_hreset            clock, asynchronous active-low reset
//   dma_wr/dma_wdata/dma_wbyte DMA write strobe, data, byte-lane enables
//   dma_rd/dma_rd_word        DMA read strobe, 1 = word pop, 0 = byte pop
//   dma_rdata                 registered read data
//   slot_av                   TX FIFO has at least 4 free bytes
//   data_av                   RX data available for the DMA
//   word_av                   RX FIFO holds at least 4 bytes
//   per_tx_data/valid/ready   TX byte stream towards the peripheral
//   per_rx_data/valid/ready   RX byte stream from the peripheral
//   flag_clr                  clears the sticky error flags
//   tx_ovf                    sticky: DMA write while slot_av was low
//   rx_unf                    sticky: DMA read while the RX FIFO was short
// ============================================================================
module dma_periph_flow_if #(
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16,
  parameter int TIMEOUT  = 32
) (
  input  logic        hclk,
  input  logic        n_hreset,
  input  logic        dma_wr,
  input  logic [31:0] dma_wdata,
  input  logic [3:0]  dma_wbyte,
  input  logic        dma_rd,
  input  logic        dma_rd_word,
  output logic [31:0] dma_rdata,
  output logic        slot_av,
  output logic        data_av,
  output logic        word_av,
  output logic [7:0]  per_tx_data,
  output logic        per_tx_valid,
  input  logic        per_tx_ready,
  input  logic [7:0]  per_rx_data,
  input  logic        per_rx_valid,
  output logic        per_rx_ready,
  input  logic        flag_clr,
  output logic        tx_ovf,
  output logic        rx_unf
);

  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);

  // slot_av means free >= 4, i.e. count <= depth-4
  localparam logic [TAW:0] TX_FREE_MAX = (TAW+1)'(TX_DEPTH - 4);
  localparam logic [RAW:0] RX_FULL     = (RAW+1)'(RX_DEPTH);
  localparam logic [RAW:0] RX_WORD     = (RAW+1)'(4);

  // --------------------------------------------------------------------------
  // TX FIFO
  // --------------------------------------------------------------------------
  logic [7:0]     tx_mem [TX_DEPTH];
  logic [TAW-1:0] tx_wr_ptr_reg;
  logic [TAW-1:0] tx_rd_ptr_reg;
  logic [TAW:0]   tx_count_reg;
  logic [TAW:0]   tx_count_next;
  logic           tx_push;
  logic           tx_pop;
  logic [2:0]     tx_push_n;
  logic [2:0]     lane_off [4];
  logic           tx_ovf_reg;

  assign slot_av      = (tx_count_reg <= TX_FREE_MAX);
  assign per_tx_valid = (tx_count_reg != '0);
  assign per_tx_data  = tx_mem[tx_rd_ptr_reg];

  // Capacity is judged on the start-of-cycle count; slot_av guarantees room
  // for a full word even if nothing drains this cycle.
  assign tx_push   = dma_wr & slot_av;
  assign tx_pop    = per_tx_valid & per_tx_ready;
  assign tx_push_n = 3'($countones(dma_wbyte));

  // Enabled lanes are packed: each lane lands at an offset equal to the
  // number of enabled lanes below it, so bytes stay in ascending lane order.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane_off
      if (gi == 0) begin : g_first
        assign lane_off[gi] = 3'd0;
      end else begin : g_rest
        assign lane_off[gi] = 3'($countones(dma_wbyte[gi-1:0]));
      end
    end
  endgenerate

  always_comb begin
    tx_count_next = tx_count_reg;
    if (tx_push) tx_count_next = tx_count_next + (TAW+1)'(tx_push_n);
    if (tx_pop)  tx_count_next = tx_count_next - (TAW+1)'(1);
  end

  always_ff @(posedge hclk or negedge n_hreset) begin
    if (!n_hreset) begin
      tx_wr_ptr_reg <= '0;
      tx_rd_ptr_reg <= '0;
      tx_count_reg  <= '0;
      tx_ovf_reg    <= 1'b0;
    end else begin
      if (tx_push) tx_wr_ptr_reg <= tx_wr_ptr_reg + TAW'(tx_push_n);
      if (tx_pop)  tx_rd_ptr_reg <= tx_rd_ptr_reg + TAW'(1);
      tx_count_reg <= tx_count_next;
      // set wins over clear
      tx_ovf_reg   <= (dma_wr & ~slot_av) | (tx_ovf_reg & ~flag_clr);
    end
  end

  // Storage needs no reset: pointers and counts define what is valid.
  always_ff @(posedge hclk) begin
    if (tx_push) begin
      for (int i = 0; i < 4; i++) begin
        if (dma_wbyte[i]) tx_mem[tx_wr_ptr_reg + TAW'(lane_off[i])] <= dma_wdata[8*i +: 8];
      end
    end
  end

  assign tx_ovf = tx_ovf_reg;

  // --------------------------------------------------------------------------
  // RX FIFO
  // --------------------------------------------------------------------------
  logic [7:0]     rx_mem [RX_DEPTH];
  logic [RAW-1:0] rx_wr_ptr_reg;
  logic [RAW-1:0] rx_rd_ptr_reg;
  logic [RAW:0]   rx_count_reg;
  logic [RAW:0]   rx_count_next;
  logic           rx_push;
  logic           rx_rd_ok;
  logic [2:0]     rx_pop_n;
  logic [7:0]     rx_byte [4];
  logic [31:0]    rx_rdata_next;
  logic [31:0]    dma_rdata_reg;
  logic           rx_unf_reg;

  assign per_rx_ready = (rx_count_reg != RX_FULL);
  assign word_av      = (rx_count_reg >= RX_WORD);

  // A held-off byte simply stays on per_rx_data until per_rx_ready returns.
  assign rx_push  = per_rx_valid & per_rx_ready;
  assign rx_rd_ok = dma_rd & (dma_rd_word ? word_av : (rx_count_reg != '0));
  assign rx_pop_n = !rx_rd_ok ? 3'd0 : (dma_rd_word ? 3'd4 : 3'd1);

  // The four oldest bytes, read relative to the (wrapping) read pointer.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_rx_peek
      assign rx_byte[gi] = rx_mem[rx_rd_ptr_reg + RAW'(gi)];
    end
  endgenerate

  always_comb begin
    rx_rdata_next = '0;
    if (rx_rd_ok) begin
      if (dma_rd_word) rx_rdata_next = {rx_byte[3], rx_byte[2], rx_byte[1], rx_byte[0]};
      else             rx_rdata_next = {24'd0, rx_byte[0]};
    end
  end

  always_comb begin
    rx_count_next = rx_count_reg + (RAW+1)'(rx_push) - (RAW+1)'(rx_pop_n);
  end

  always_ff @(posedge hclk or negedge n_hreset) begin
    if (!n_hreset) begin
      rx_wr_ptr_reg <= '0;
      rx_rd_ptr_reg <= '0;
      rx_count_reg  <= '0;
      dma_rdata_reg <= '0;
      rx_unf_reg    <= 1'b0;
    end else begin
      if (rx_push) rx_wr_ptr_reg <= rx_wr_ptr_reg + RAW'(1);
      rx_rd_ptr_reg <= rx_rd_ptr_reg + RAW'(rx_pop_n);
      rx_count_reg  <= rx_count_next;
      // A short read returns zero; between reads the last value is held.
      if (dma_rd) dma_rdata_reg <= rx_rdata_next;
      rx_unf_reg    <= (dma_rd & ~rx_rd_ok) | (rx_unf_reg & ~flag_clr);
    end
  end

  always_ff @(posedge hclk) begin
    if (rx_push) rx_mem[rx_wr_ptr_reg] <= per_rx_data;
  end

  assign dma_rdata = dma_rdata_reg;
  assign rx_unf    = rx_unf_reg;

  // --------------------------------------------------------------------------
  // data_av
  // --------------------------------------------------------------------------
`ifdef DMA_FLOW_RXTIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT);

  logic [IW-1:0] idle_reg;
  logic          rx_partial;

  assign rx_partial = (rx_count_reg != '0) & ~word_av;

  // Counts quiet cycles while a partial word sits in the FIFO; any RX
  // activity restarts the wait.
  always_ff @(posedge hclk or negedge n_hreset) begin
    if (!n_hreset) begin
      idle_reg <= '0;
    end else if (rx_push | rx_rd_ok) begin
      idle_reg <= '0;
    end else if (rx_partial) begin
      if (idle_reg != IDLE_MAX) idle_reg <= idle_reg + IW'(1);
    end else begin
      idle_reg <= '0;
    end
  end

  assign data_av = word_av | ((rx_count_reg != '0) & (idle_reg == IDLE_MAX));
`else
  assign data_av = (rx_count_reg != '0);
`endif

endmodule

// File: tb/tb_dma_periph_flow_if.sv
module tb_dma_periph_flow_if;

  localparam int TXD = 16;
  localparam int RXD = 16;
  localparam int TMO = 32;

  logic        hclk = 1'b0;
  logic        n_hreset = 1'b1;
  logic        dma_wr;
  logic [31:0] dma_wdata;
  logic [3:0]  dma_wbyte;
  logic        dma_rd;
  logic        dma_rd_word;
  logic [31:0] dma_rdata;
  logic        slot_av;
  logic        data_av;
  logic        word_av;
  logic [7:0]  per_tx_data;
  logic        per_tx_valid;
  logic        per_tx_ready;
  logic [7:0]  per_rx_data;
  logic        per_rx_valid;
  logic        per_rx_ready;
  logic        flag_clr;
  logic        tx_ovf;
  logic        rx_unf;

  always #5 hclk = ~hclk;

  dma_periph_flow_if #(.TX_DEPTH(TXD), .RX_DEPTH(RXD), .TIMEOUT(TMO)) dut (
    .hclk(hclk), .n_hreset(n_hreset),
    .dma_wr(dma_wr), .dma_wdata(dma_wdata), .dma_wbyte(dma_wbyte),
    .dma_rd(dma_rd), .dma_rd_word(dma_rd_word), .dma_rdata(dma_rdata),
    .slot_av(slot_av), .data_av(data_av), .word_av(word_av),
    .per_tx_data(per_tx_data), .per_tx_valid(per_tx_valid), .per_tx_ready(per_tx_ready),
    .per_rx_data(per_rx_data), .per_rx_valid(per_rx_valid), .per_rx_ready(per_rx_ready),
    .flag_clr(flag_clr), .tx_ovf(tx_ovf), .rx_unf(rx_unf)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: byte queues plus flags, driven by the rules directly.
  byte unsigned tx_q[$];
  byte unsigned rx_q[$];
  logic         m_tx_ovf;
  logic         m_rx_unf;
  logic [31:0]  m_rdata;
  int           m_idle;   // cycles since last successful RX push/pop

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_data_av();
`ifdef DMA_FLOW_RXTIMEOUT_EN
    return (rx_q.size() >= 4) || (rx_q.size() != 0 && m_idle >= TMO);
`else
    return rx_q.size() != 0;
`endif
  endfunction

  task automatic check_all();
    chk("slot_av", slot_av, (TXD - tx_q.size()) >= 4);
    chk("per_tx_valid", per_tx_valid, tx_q.size() != 0);
    if (tx_q.size() != 0) chk("per_tx_data", per_tx_data, tx_q[0]);
    chk("per_rx_ready", per_rx_ready, rx_q.size() < RXD);
    chk("word_av", word_av, rx_q.size() >= 4);
    chk("data_av", data_av, exp_data_av());
    chk("dma_rdata", dma_rdata, m_rdata);
    chk("tx_ovf", tx_ovf, m_tx_ovf);
    chk("rx_unf", rx_unf, m_rx_unf);
  endtask

  task automatic model_reset();
    tx_q.delete();
    rx_q.delete();
    m_tx_ovf = 1'b0;
    m_rx_unf = 1'b0;
    m_rdata  = '0;
    m_idle   = 0;
  endtask

  // Apply one clock edge's worth of effects using the current inputs and the
  // start-of-cycle model state.
  task automatic model_edge();
    int          tn;
    int          rn;
    int          need;
    bit          slot;
    bit          rx_act;
    bit          set_unf;
    logic [31:0] d;
    tn = tx_q.size();
    rn = rx_q.size();
    slot = (TXD - tn) >= 4;
    rx_act = 0;
    set_unf = 0;
    if (per_tx_ready && tn != 0) void'(tx_q.pop_front());
    if (dma_wr && slot) begin
      for (int i = 0; i < 4; i++) if (dma_wbyte[i]) tx_q.push_back(dma_wdata[8*i +: 8]);
    end
    m_tx_ovf = (dma_wr && !slot) ? 1'b1 : (flag_clr ? 1'b0 : m_tx_ovf);
    if (dma_rd) begin
      need = dma_rd_word ? 4 : 1;
      if (rn >= need) begin
        d = '0;
        for (int k = 0; k < need; k++) d[8*k +: 8] = rx_q.pop_front();
        m_rdata = d;
        rx_act = 1;
      end else begin
        m_rdata = '0;
        set_unf = 1;
      end
    end
    if (per_rx_valid && rn < RXD) begin
      rx_q.push_back(per_rx_data);
      rx_act = 1;
    end
    m_rx_unf = set_unf ? 1'b1 : (flag_clr ? 1'b0 : m_rx_unf);
    if (rx_act) m_idle = 0;
    else        m_idle++;
  endtask

  task automatic cycle();
    model_edge();
    @(posedge hclk);
    #1;
    check_all();
  endtask

  task automatic clear_in();
    dma_wr = 0; dma_wdata = '0; dma_wbyte = '0;
    dma_rd = 0; dma_rd_word = 0;
    per_tx_ready = 0; per_rx_data = '0; per_rx_valid = 0;
    flag_clr = 0;
  endtask

  // Reset is asserted between edges and checked before any clock edge.
  task automatic do_reset();
    n_hreset = 1'b0;
    #2;
    model_reset();
    check_all();
    @(posedge hclk);
    #1;
    n_hreset = 1'b1;
    check_all();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] w0;
    logic [31:0] first_w;
    clear_in();
    #3;
    do_reset();

    // T1 reset values
    chk("t1_slot_av", slot_av, 1'b1);
    chk("t1_data_av", data_av, 1'b0);
    chk("t1_word_av", word_av, 1'b0);
    chk("t1_per_rx_ready", per_rx_ready, 1'b1);
    chk("t1_dma_rdata", dma_rdata, 32'h0);

    // T2 TX word, drained byte by byte in lane order
    w0 = 32'h44332211;
    dma_wr = 1; dma_wdata = w0; dma_wbyte = 4'hF;
    cycle();
    clear_in();
    per_tx_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk("t2_byte", per_tx_data, w0[8*i +: 8]);
      cycle();
    end
    per_tx_ready = 0;
    chk("t2_empty", per_tx_valid, 1'b0);

    // fill to 16, then overflow
    first_w = 32'hA1B2C3D4;
    for (int i = 0; i < 4; i++) begin
      dma_wr = 1; dma_wbyte = 4'hF;
      dma_wdata = (i == 0) ? first_w : $urandom;
      cycle();
    end
    chk("t2_full_slot_av", slot_av, 1'b0);
    dma_wdata = 32'hDEADBEEF;
    cycle();
    chk("t2_tx_ovf", tx_ovf, 1'b1);
    chk("t2_head_unchanged", per_tx_data, first_w[7:0]);
    flag_clr = 1;
    cycle();
    chk("t2_set_wins", tx_ovf, 1'b1);
    dma_wr = 0;
    cycle();
    chk("t2_cleared", tx_ovf, 1'b0);
    clear_in();
    per_tx_ready = 1;
    repeat (16) cycle();
    clear_in();

    // sparse lanes and an empty lane mask
    dma_wr = 1; dma_wdata = 32'hDDCCBBAA; dma_wbyte = 4'b1010;
    cycle();
    chk("t2_sparse_head", per_tx_data, 8'hBB);
    dma_wbyte = 4'b0000;
    cycle();
    clear_in();
    per_tx_ready = 1;
    cycle();
    chk("t2_sparse_second", per_tx_data, 8'hDD);
    cycle();
    clear_in();

    // T3 RX word
    for (int i = 0; i < 4; i++) begin
      per_rx_valid = 1;
      per_rx_data = 8'hAA + 8'(i * 17);
      cycle();
      chk("t3_word_av", word_av, i == 3);
    end
    clear_in();
    dma_rd = 1; dma_rd_word = 1;
    cycle();
    clear_in();
    chk("t3_rdata", dma_rdata, 32'hDDCCBBAA);
    chk("t3_word_av_after", word_av, 1'b0);

    // T4 short read, then byte read, then hold
    per_rx_valid = 1; per_rx_data = 8'h01;
    cycle();
    clear_in();
    dma_rd = 1; dma_rd_word = 1;
    cycle();
    chk("t4_short_rdata", dma_rdata, 32'h0);
    chk("t4_rx_unf", rx_unf, 1'b1);
    dma_rd_word = 0;
    cycle();
    clear_in();
    chk("t4_byte_rdata", dma_rdata, 32'h00000001);
    cycle();
    chk("t4_hold", dma_rdata, 32'h00000001);
    flag_clr = 1;
    cycle();
    clear_in();

    // T5 full, held-off byte, simultaneous push/pop at count 15
    for (int i = 0; i < RXD; i++) begin
      per_rx_valid = 1; per_rx_data = 8'(i + 8'h30);
      cycle();
    end
    chk("t5_full", per_rx_ready, 1'b0);
    per_rx_data = 8'hEE;
    cycle();
    clear_in();
    dma_rd = 1;
    cycle();
    chk("t5_first_byte", dma_rdata, 32'h00000030);
    per_rx_valid = 1; per_rx_data = 8'hEE;
    cycle();
    chk("t5_simul_rdata", dma_rdata, 32'h00000031);
    chk("t5_simul_ready", per_rx_ready, 1'b1);
    dma_rd = 0; per_rx_data = 8'h5A;
    cycle();
    clear_in();
    chk("t5_refull", per_rx_ready, 1'b0);

    // reset mid-fill
    per_tx_ready = 0; dma_wr = 1; dma_wdata = $urandom; dma_wbyte = 4'hF;
    cycle();
    clear_in();
    do_reset();
    chk("rst_word_av", word_av, 1'b0);
    chk("rst_per_rx_ready", per_rx_ready, 1'b1);
    chk("rst_per_tx_valid", per_tx_valid, 1'b0);

`ifdef DMA_FLOW_RXTIMEOUT_EN
    // T6 partial-word timeout
    per_rx_valid = 1; per_rx_data = 8'h77;
    cycle();
    clear_in();
    for (int i = 1; i <= TMO; i++) begin
      cycle();
      if (i == TMO - 1) chk("t6_before", data_av, 1'b0);
      if (i == TMO)     chk("t6_at", data_av, 1'b1);
    end
    dma_rd = 1;
    cycle();
    clear_in();
`endif

    // randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      dma_wr       = ($urandom_range(0, 9) < 3);
      dma_wdata    = $urandom;
      dma_wbyte    = 4'($urandom);
      dma_rd       = ($urandom_range(0, 9) < 3);
      dma_rd_word  = $urandom_range(0, 1);
      per_tx_ready = $urandom_range(0, 1);
      per_rx_valid = $urandom_range(0, 1);
      per_rx_data  = 8'($urandom);
      flag_clr     = ($urandom_range(0, 9) == 0);
      cycle();
    end
    clear_in();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
